// File: rtl/date_keeper_cfg.sv
`default_nettype none
// ============================================================================
// Module   : date_keeper_cfg
// Purpose  : Calendar date keeper with Gregorian leap handling, interactive
//            key-driven edit mode and a six-digit BCD display with a
//            blinking edit field.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            carry_in           - one-cycle day rollover pulse
//            mode               - 1 allows entering edit mode
//            up/down/left/right - edit keys (one-cycle pulses)
//            enter/esc          - enter edit / commit, abandon edit
//            fmt[1:0]           - display order (0/3 YYMMDD, 1 MMDDYY, 2 DDMMYY)
//            out[47:0]          - six bytes {blank,3'b000,bcd}, [47:40] leftmost
//            norm               - 1 in RUN, 0 in EDIT (registered)
//            year/month/day     - live date (year is an offset from YEAR_BASE)
// Revision : 1.0 - initial release
// ============================================================================
module date_keeper_cfg #(
  parameter int YEAR_BASE  = 2000,
  parameter int YEAR_SPAN  = 100,
  parameter int INIT_YEAR  = 0,
  parameter int INIT_MONTH = 1,
  parameter int INIT_DAY   = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        carry_in,
  input  logic        mode,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        enter,
  input  logic        esc,
  input  logic [1:0]  fmt,
  output logic [47:0] out,
  output logic        norm,
  output logic [6:0]  year,
  output logic [6:0]  month,
  output logic [6:0]  day
);

  localparam int             CW           = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  C_BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0]     C_YEAR_LAST  = 7'(YEAR_SPAN - 1);

  localparam logic [1:0] F_YEAR  = 2'd0;
  localparam logic [1:0] F_MONTH = 2'd1;
  localparam logic [1:0] F_DAY   = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  function automatic logic is_leap(input logic [6:0] yoff);
    int y;
    y = YEAR_BASE + int'(yoff);
    return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
  endfunction

  function automatic logic [6:0] month_len(input logic [6:0] m, input logic [6:0] yoff);
    case (m)
      7'd2:                    month_len = is_leap(yoff) ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: month_len = 7'd30;
      default:                 month_len = 7'd31;
    endcase
  endfunction

  function automatic logic [15:0] pair_bytes(input logic [6:0] v, input logic blank);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {blank, 3'b000, tens, blank, 3'b000, units};
  endfunction

  // Which field sits at display pair position cur for a given order.
  function automatic logic [1:0] field_sel(input logic [1:0] f, input logic [1:0] cur);
    case (f)
      2'd1: begin
        case (cur)
          2'd0:    field_sel = F_MONTH;
          2'd1:    field_sel = F_DAY;
          default: field_sel = F_YEAR;
        endcase
      end
      2'd2: begin
        case (cur)
          2'd0:    field_sel = F_DAY;
          2'd1:    field_sel = F_MONTH;
          default: field_sel = F_YEAR;
        endcase
      end
      default: begin
        case (cur)
          2'd0:    field_sel = F_YEAR;
          2'd1:    field_sel = F_MONTH;
          default: field_sel = F_DAY;
        endcase
      end
    endcase
  endfunction

  function automatic logic [6:0] field_val(input logic [1:0] sel, input logic [6:0] y,
                                           input logic [6:0] m, input logic [6:0] d);
    case (sel)
      F_YEAR:  field_val = y % 7'd100;
      F_MONTH: field_val = m;
      default: field_val = d;
    endcase
  endfunction

  // Reset display is fixed in YYMMDD order since fmt is not sampled in reset.
  localparam logic [47:0] C_INIT_OUT = {pair_bytes(7'(INIT_YEAR % 100), 1'b0),
                                        pair_bytes(7'(INIT_MONTH), 1'b0),
                                        pair_bytes(7'(INIT_DAY), 1'b0)};

  state_t        state_q, state_d;
  logic [6:0]    year_q, year_d, month_q, month_d, day_q, day_d;
  logic [6:0]    sh_year_q, sh_year_d, sh_month_q, sh_month_d, sh_day_q, sh_day_d;
  logic [1:0]    cursor_q, cursor_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [47:0]   out_q, out_d;
  logic          norm_q, norm_d;

  logic          commit;
  logic          enter_edit;
  logic [6:0]    live_len;
  logic [6:0]    sh_len;
  logic [1:0]    edit_sel;
  logic [6:0]    ed_year, ed_month, ed_len;
  logic [6:0]    disp_year, disp_month, disp_day;

  assign enter_edit = (state_q == ST_RUN) && enter && mode;
  assign commit     = (state_q == ST_EDIT) && !esc && enter;
  assign live_len   = month_len(month_q, year_q);
  assign sh_len     = month_len(sh_month_q, sh_year_q);
  assign edit_sel   = field_sel(fmt, cursor_q);

  // Live date: a commit overrides a coincident carry, which is then lost.
  always_comb begin
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    if (commit) begin
      year_d  = sh_year_q;
      month_d = sh_month_q;
      day_d   = sh_day_q;
    end else if (carry_in) begin
      if (day_q >= live_len) begin
        day_d = 7'd1;
        if (month_q >= 7'd12) begin
          month_d = 7'd1;
          year_d  = (year_q >= C_YEAR_LAST) ? 7'd0 : year_q + 7'd1;
        end else begin
          month_d = month_q + 7'd1;
        end
      end else begin
        day_d = day_q + 7'd1;
      end
    end
  end

  // State, shadow date and cursor.
  always_comb begin
    state_d    = state_q;
    sh_year_d  = sh_year_q;
    sh_month_d = sh_month_q;
    sh_day_d   = sh_day_q;
    cursor_d   = cursor_q;
    ed_year    = sh_year_q;
    ed_month   = sh_month_q;
    ed_len     = sh_len;
    case (state_q)
      ST_RUN: begin
        if (enter_edit) begin
          state_d    = ST_EDIT;
          sh_year_d  = year_q;
          sh_month_d = month_q;
          sh_day_d   = day_q;
          cursor_d   = 2'd0;
        end
      end
      default: begin
        if (esc || enter) begin
          state_d = ST_RUN;
        end else if (up || down) begin
          // Both keys together still consume the cycle but change nothing.
          if (up ^ down) begin
            case (edit_sel)
              F_YEAR: begin
                if (up) ed_year = (sh_year_q >= C_YEAR_LAST) ? 7'd0 : sh_year_q + 7'd1;
                else    ed_year = (sh_year_q == 7'd0) ? C_YEAR_LAST : sh_year_q - 7'd1;
              end
              F_MONTH: begin
                if (up) ed_month = (sh_month_q >= 7'd12) ? 7'd1 : sh_month_q + 7'd1;
                else    ed_month = (sh_month_q <= 7'd1) ? 7'd12 : sh_month_q - 7'd1;
              end
              default: begin
                if (up) sh_day_d = (sh_day_q >= sh_len) ? 7'd1 : sh_day_q + 7'd1;
                else    sh_day_d = (sh_day_q <= 7'd1) ? sh_len : sh_day_q - 7'd1;
              end
            endcase
            if (edit_sel != F_DAY) begin
              ed_len     = month_len(ed_month, ed_year);
              sh_year_d  = ed_year;
              sh_month_d = ed_month;
              sh_day_d   = (sh_day_q > ed_len) ? ed_len : sh_day_q;
            end
          end
        end else if (left ^ right) begin
          if (right) cursor_d = (cursor_q >= 2'd2) ? 2'd0 : cursor_q + 2'd1;
          else       cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
        end
      end
    endcase
  end

  assign disp_year  = (state_q == ST_EDIT) ? sh_year_q  : year_q;
  assign disp_month = (state_q == ST_EDIT) ? sh_month_q : month_q;
  assign disp_day   = (state_q == ST_EDIT) ? sh_day_q   : day_q;

  // Blink timing and registered display.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    out_d       = '0;
    norm_d      = (state_q == ST_RUN);
    if (enter_edit) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == C_BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
    for (int p = 0; p < 3; p++) begin
      out_d[47-16*p -: 16] = pair_bytes(
          field_val(field_sel(fmt, 2'(p)), disp_year, disp_month, disp_day),
          (state_q == ST_EDIT) && (cursor_q == 2'(p)) && phase_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      year_q      <= 7'(INIT_YEAR);
      month_q     <= 7'(INIT_MONTH);
      day_q       <= 7'(INIT_DAY);
      sh_year_q   <= 7'(INIT_YEAR);
      sh_month_q  <= 7'(INIT_MONTH);
      sh_day_q    <= 7'(INIT_DAY);
      cursor_q    <= 2'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      out_q       <= C_INIT_OUT;
      norm_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      sh_year_q   <= sh_year_d;
      sh_month_q  <= sh_month_d;
      sh_day_q    <= sh_day_d;
      cursor_q    <= cursor_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      norm_q      <= norm_d;
    end
  end

  assign out   = out_q;
  assign norm  = norm_q;
  assign year  = year_q;
  assign month = month_q;
  assign day   = day_q;

endmodule
`default_nettype wire
